// File: rtl/jk_pkg.sv
// Shared types and constants for the JK excitation driver.
package jk_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        SETUP,
        FALL,
        CHECK
    } state_t;

    // Excitation pairs packed as {J, K}
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_TGL  = 2'b11;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/jk_excite_bit.sv
// Single-bit JK excitation: derives (J, K) from current Q and desired next Q.
// JK_TOGGLE_PREF_EN selects toggle excitation for changing bits.
module jk_excite_bit
    import jk_pkg::*;
(
    input  logic q,
    input  logic tgt,
    output logic j,
    output logic k
);

    logic [1:0] jk;

    // Don't-care entries of the table are resolved to 0; unknown Q falls to hold.
    always_comb begin
        jk = JK_HOLD;
        case ({q, tgt})
`ifdef JK_TOGGLE_PREF_EN
            2'b01:   jk = JK_TGL;
            2'b10:   jk = JK_TGL;
`else
            2'b01:   jk = JK_SET;
            2'b10:   jk = JK_RST;
`endif
            default: jk = JK_HOLD;
        endcase
    end

    assign j = jk[1];
    assign k = jk[0];

endmodule

// File: rtl/jk_excitation_driver.sv
// Stimulus and checker front-end for a bank of master-slave JK flops.
// Accepts a target vector, drives J/K from the excitation table, pulses the
// bank clock, waits for settling and then compares the returned Q.
// Optional build macro: JK_TOGGLE_PREF_EN (toggle excitation for changing bits).
//
// state | meaning
// INIT  | bank held in reset for one cycle after reset release
// IDLE  | ready for a target, bank clock low
// SETUP | bank clock high, master loads from J/K
// FALL  | bank clock low, slave settling for SETTLE_CYCLES cycles
// CHECK | compare Q to target, emit done pulse, clear J/K
module jk_excitation_driver
    import jk_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_target,
    output logic [WIDTH-1:0] jk_j,
    output logic [WIDTH-1:0] jk_k,
    output logic             jk_clk,
    output logic             jk_reset_n,
    input  logic [WIDTH-1:0] jk_q,
    output logic             done_valid,
    output logic             done_ok,
    output logic [ERR_W-1:0] err_count
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] j_reg;
    logic [WIDTH-1:0] k_reg;
    logic [WIDTH-1:0] j_exc;
    logic [WIDTH-1:0] k_exc;
    logic [CNT_W-1:0] settle_cnt;
    logic             accept;
    logic             match;

    assign accept = (state == IDLE) && in_valid;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_excite_bit u_bit (
            .q   (jk_q[i]),
            .tgt (in_target[i]),
            .j   (j_exc[i]),
            .k   (k_exc[i])
        );
    end

    // Unknown Q resolves to a mismatch because the if only fires on a true compare.
    always_comb begin
        match = 1'b0;
        if (jk_q == tgt) begin
            match = 1'b1;
        end
    end

    // State register; reset parks in INIT so the bank reset is held through release.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    state_nxt = IDLE;
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = FALL;
            FALL:    if (settle_cnt == '0) state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = INIT;
        endcase
    end

    // Captured target, excitation, settle timer and saturating mismatch counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            tgt        <= '0;
            j_reg      <= '0;
            k_reg      <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
        end else begin
            if (accept) begin
                tgt   <= in_target;
                j_reg <= j_exc;
                k_reg <= k_exc;
            end
            if (state == SETUP) begin
                settle_cnt <= CNT_LOAD;
            end else if ((state == FALL) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - CNT_W'(1);
            end
            if (state == CHECK) begin
                j_reg <= '0;
                k_reg <= '0;
                if (!match && (err_count != '1)) begin
                    err_count <= err_count + ERR_W'(1);
                end
            end
        end
    end

    // Moore outputs; J/K reach the bank only while the pulse and settle are in progress.
    always_comb begin
        in_ready   = 1'b0;
        jk_clk     = 1'b0;
        jk_reset_n = 1'b1;
        jk_j       = '0;
        jk_k       = '0;
        done_valid = 1'b0;
        done_ok    = 1'b0;
        case (state)
            INIT:    jk_reset_n = 1'b0;
            IDLE:    in_ready = 1'b1;
            SETUP: begin
                jk_clk = 1'b1;
                jk_j   = j_reg;
                jk_k   = k_reg;
            end
            FALL: begin
                jk_j = j_reg;
                jk_k = k_reg;
            end
            CHECK: begin
                done_valid = 1'b1;
                done_ok    = match;
            end
            default: jk_reset_n = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: behavioural JK bank, transaction-timeline model
// compared every cycle, plus directed literal expectations.
module tb_jk_excitation_driver;

    localparam int W  = 4;
    localparam int S  = 2;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_target = '0;
    logic          in_ready;
    logic [W-1:0]  jk_j;
    logic [W-1:0]  jk_k;
    logic          jk_clk;
    logic          jk_reset_n;
    logic [W-1:0]  jk_q;
    logic          done_valid;
    logic          done_ok;
    logic [EW-1:0] err_count;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    jk_excitation_driver #(.WIDTH(W), .SETTLE_CYCLES(S), .ERR_W(EW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_target  (in_target),
        .jk_j       (jk_j),
        .jk_k       (jk_k),
        .jk_clk     (jk_clk),
        .jk_reset_n (jk_reset_n),
        .jk_q       (jk_q),
        .done_valid (done_valid),
        .done_ok    (done_ok),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Behavioural master-slave JK bank with optional stuck-at-0 outputs
    logic [W-1:0] bq = '0;
    logic [W-1:0] master = '0;
    logic [W-1:0] stuck_mask = '0;
    logic         prev_clk = 1'b0;
    assign jk_q = bq & ~stuck_mask;

    always @(posedge clk) begin
        #2;
        if (jk_reset_n !== 1'b1) begin
            bq     = '0;
            master = '0;
        end else begin
            if (jk_clk === 1'b1) master = (jk_j & ~bq) | (~jk_k & bq);
            if (prev_clk && (jk_clk === 1'b0)) bq = master;
        end
        prev_clk = (jk_clk === 1'b1);
    end

    // Transaction timeline model: age counts cycles since acceptance
    bit           m_init = 1'b1;
    bit           m_busy = 1'b0;
    int           m_age  = 0;
    logic [W-1:0] m_tgt  = '0;
    logic [W-1:0] m_j    = '0;
    logic [W-1:0] m_k    = '0;
    int           m_err  = 0;

    always @(negedge clk) begin
        logic         e_ready, e_clk, e_rstn, e_dv, e_ok;
        logic [W-1:0] e_j, e_k, qs;
        if (cyc >= 1) begin
            e_ready = 0; e_clk = 0; e_dv = 0; e_ok = 0; e_j = '0; e_k = '0;
            e_rstn  = !m_init;
            if (!m_init) begin
                if (!m_busy) e_ready = 1;
                else begin
                    e_clk = (m_age == 1);
                    if (m_age >= 1 && m_age <= S + 1) begin
                        e_j = m_j;
                        e_k = m_k;
                    end
                    e_dv = (m_age == S + 2);
                    e_ok = e_dv && (jk_q === m_tgt);
                end
            end
            chk("in_ready",   in_ready,   e_ready);
            chk("jk_clk",     jk_clk,     e_clk);
            chk("jk_reset_n", jk_reset_n, e_rstn);
            chk("jk_j",       jk_j,       e_j);
            chk("jk_k",       jk_k,       e_k);
            chk("done_valid", done_valid, e_dv);
            chk("done_ok",    done_ok,    e_ok);
            chk("err_count",  err_count,  m_err);

            if (reset) begin
                m_init = 1; m_busy = 0; m_err = 0;
            end else if (m_init) begin
                m_init = 0;
            end else if (!m_busy) begin
                if (in_valid) begin
                    qs     = jk_q;
                    m_busy = 1;
                    m_age  = 1;
                    m_tgt  = in_target;
`ifdef JK_TOGGLE_PREF_EN
                    m_j = qs ^ in_target;
                    m_k = qs ^ in_target;
`else
                    m_j = ~qs & in_target;
                    m_k = qs & ~in_target;
`endif
                end
            end else if (m_age == S + 2) begin
                m_busy = 0;
                if ((jk_q !== m_tgt) && (m_err != 255)) m_err++;
            end else begin
                m_age++;
            end
        end
    end

    // One target, with literal checks on the clock pulse, J/K and latency
    task automatic do_txn(input logic [W-1:0] t, input logic [W-1:0] ej, input logic [W-1:0] ek,
                          input logic eok, input bit lit);
        int n;
        int lat;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_target = t;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_target = ~t;
        @(negedge clk);
        if (lit) begin
            chk("setup_clk", jk_clk, 1);
            chk("setup_j", jk_j, ej);
            chk("setup_k", jk_k, ek);
        end
        lat = 1;
        while (!done_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (lit) begin
            chk("latency", lat, S + 2);
            chk("done_ok_lit", done_ok, eok);
        end else if (!done_valid) begin
            chk("done_timeout", done_valid, 1);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] seq_t [3];
        int           acc [3];
        int           k, dv_seen;

        // Reset and release
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("init_rstn", jk_reset_n, 0);
        chk("init_ready", in_ready, 0);
        @(negedge clk);
        chk("idle_rstn", jk_reset_n, 1);
        chk("idle_ready", in_ready, 1);
        chk("idle_err", err_count, 0);

        // Q=0000 -> 1010
        do_txn(4'b1010, 4'b1010, 4'b0000, 1'b1, 1);
        @(negedge clk);
        chk("after_clk_low", jk_clk, 0);

        // Q=1010 -> 0110
`ifdef JK_TOGGLE_PREF_EN
        do_txn(4'b0110, 4'b1100, 4'b1100, 1'b1, 1);
`else
        do_txn(4'b0110, 4'b0100, 4'b1000, 1'b1, 1);
`endif
        // Target equal to current Q
        do_txn(4'b0110, 4'b0000, 4'b0000, 1'b1, 1);

        // Stuck-at-0 on bit 0
        stuck_mask = 4'b0001;
`ifdef JK_TOGGLE_PREF_EN
        do_txn(4'b0001, 4'b0111, 4'b0111, 1'b0, 1);
`else
        do_txn(4'b0001, 4'b0001, 4'b0110, 1'b0, 1);
`endif
        @(negedge clk);
        chk("err_one", err_count, 1);
        for (int i = 1; i < 300; i++) begin
`ifdef JK_TOGGLE_PREF_EN
            do_txn(4'b0001, 4'b0001, 4'b0001, 1'b0, (i < 3));
`else
            do_txn(4'b0001, 4'b0001, 4'b0000, 1'b0, (i < 3));
`endif
        end
        @(negedge clk);
        chk("err_sat", err_count, 255);
        stuck_mask = '0;

        // Back-to-back with in_valid held
        seq_t[0] = 4'b0011; seq_t[1] = 4'b1100; seq_t[2] = 4'b1111;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_target = seq_t[0];
        k = 0;
        for (int c = 0; c < 40 && k < 3; c++) begin
            @(negedge clk);
            if (in_ready) begin
                acc[k] = cyc;
                k++;
                @(posedge clk); #1;
                if (k < 3) in_target = seq_t[k];
                else in_valid = 1'b0;
            end
        end
        chk("b2b_count", k, 3);
        if (k == 3) begin
            chk("b2b_gap1", acc[1] - acc[0], S + 3);
            chk("b2b_gap2", acc[2] - acc[1], S + 3);
        end
        repeat (8) @(negedge clk);

        // Reset during FALL
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_target = 4'b0101;
        @(negedge clk);
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("fall_state_clk", jk_clk, 0);
        @(negedge clk);
        chk("rst_dv", done_valid, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_rstn", jk_reset_n, 0);
        chk("rst_j", jk_j, 0);
        chk("rst_err", err_count, 0);
        @(posedge clk); #1 reset = 1'b0;
        dv_seen = 0;
        @(negedge clk);
        chk("rel_init_rstn", jk_reset_n, 0);
        if (done_valid) dv_seen++;
        @(negedge clk);
        chk("rel_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done_valid) dv_seen++;
        end
        chk("no_done_after_abort", dv_seen, 0);

        // Fresh bank after reset
`ifdef JK_TOGGLE_PREF_EN
        do_txn(4'b0101, 4'b0101, 4'b0101, 1'b1, 1);
`else
        do_txn(4'b0101, 4'b0101, 4'b0000, 1'b1, 1);
`endif
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
